data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-port arbiter and sequencer for the shared 64x32 data memory in the single-cycle CPU.
- Port 0 is the CPU load/store path; port 1 is the debug/program loader.
- The block holds the memory array and grants at most one access per cycle, round-robin, with optional locked bursts.
- Reads return data one cycle after acceptance.

Parameters:
- ADDR_W, 6, word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, data word width.
- BURST_MAX, 4, max consecutive locked beats a port keeps while the other port is requesting.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req0  in  1  port 0 access request; held until ack0.
- we0  in  1  port 0: 1 = write, 0 = read.
- lock0  in  1  port 0: keep the grant for the next beat.
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 request accepted this cycle; memory op done at this edge.
- rvalid0  out  1  port 0 read data valid, one cycle after a read ack.
- rdata0  out  DATA_W  port 0 read data.
- req1, we1, lock1, addr1, wdata1, ack1, rvalid1, rdata1: same as port 0, for port 1.
- owner  out  2  current state encoding: 00 IDLE, 01 OWN0, 10 OWN1.

Behaviour:
- Reset (synchronous, at clk edge with reset=1):
  - state IDLE; rr pointer = 0 (port 0 preferred next); beat counter 0.
  - ack*, rvalid* = 0; rdata* = 0.
  - Memory contents are not cleared by reset; the array initialises to all zeros at time 0.
- Arbitration is combinational on the current state and requests. At most one ack per cycle. The accepted op commits at the same edge.
- IDLE:
  - Only one req: grant that port.
  - Both req: grant the port indicated by the rr pointer.
  - Granted port is acked this cycle; go to OWNx if its lock=1, else stay IDLE.
  - rr pointer flips to the other port after every ack that ends ownership (lock=0 or forced release).
- OWNx:
  - Port x only is served. If reqx=1, ack it and increment the beat counter.
  - If the other port is requesting and the counter reaches BURST_MAX, force release to IDLE.
  - Otherwise stay in OWNx while lockx=1; go to IDLE when lockx=0.
  - If reqx=0 while in OWNx: go to IDLE with no ack (drops the lock; no deadlock).
  - Counter clears on entry to IDLE.
  - A lone requester under lock is never forced out; the counter saturates at BURST_MAX.
- Write ack: mem[addr] <= wdata at that edge. No rvalid.
- Read ack: rdata of the acked port <= mem[addr] at that edge; rvalid of that port pulses 1 the next cycle.
  - rdata holds its last value when rvalid=0.
  - The non-acked port's rdata and rvalid are unchanged (rvalid 0).
- Read-after-write to the same address on consecutive acks returns the new data. One op per cycle, so there is no same-cycle hazard.
- Requester rules:
  - While reqx=1 and ackx=0, addrx, wex and wdatax must stay stable.
  - After ackx, the requester may present a new request in the next cycle (back-to-back, 1 access per cycle max throughput).
- Reset mid-burst or mid-read: state returns to IDLE and the pending rvalid is suppressed (rvalid=0 the cycle after reset). A write already acked before the reset edge remains in memory.
- Addresses wrap naturally within ADDR_W bits; no out-of-range case exists.

Test Plan:
- Reset, then port 0 writes 0xDEADBEEF to addr 5, then reads addr 5 -> ack0 in both cycles; rvalid0=1 one cycle after the read ack with rdata0=0xDEADBEEF; ack1/rvalid1 stay 0.
- After reset, req0 and req1 assert together continuously with no lock -> acks alternate ack0, ack1, ack0, ack1; never both in one cycle.
- Port 1 runs a locked burst of 8 writes (addr 0..7) while port 0 requests from the second cycle -> exactly BURST_MAX=4 port 1 acks, then port 0 is acked; owner goes 10 then 00.
- Port 1 locked, no port 0 request, 8 beats -> all 8 port 1 acks are consecutive with no forced release; owner=10 throughout; then lock1=0 -> IDLE.
- Port 0 issues a read of addr 3 (holding 0x12345678); reset asserts the cycle after ack0 -> rvalid0=0; owner=00; a subsequent read of addr 3 returns 0x12345678 (memory preserved).
- Port 0 holds lock0=1 and drops req0 -> next cycle owner=00; port 1's pending request is acked the cycle after.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin two-port arbiter for the shared data memory.
// Port 0 is the CPU load/store path, port 1 the debug/program loader.
// One access is granted per cycle, and a port can hold the grant for a locked
// burst. Each read returns registered data one cycle after its ack.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; grant the lone requester, or the rr port if both
// ST_OWN0  | port 0 holds a locked burst; only port 0 is served
// ST_OWN1  | port 1 holds a locked burst; only port 1 is served
module data_mem_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic              lock0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        owner
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  // The array is not affected by reset; it starts out all zeros.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [1:0]       state, state_nxt;
  logic             rr, rr_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_nxt, beat_inc;
  logic             gnt0, gnt1;

  // The beat count stops at BURST_MAX, so a lone locked requester can keep
  // going without the counter wrapping.
  assign beat_inc = (beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + CNT_ONE;

  // Work out the grant and the next state, rr pointer and beat count.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    rr_nxt    = rr;
    beat_nxt  = beat_cnt;
    case (state)
      ST_OWN0: begin
        if (req0) begin
          gnt0 = 1'b1;
          if ((req1 && beat_inc == CNT_MAX) || !lock0) begin
            state_nxt = ST_IDLE;
            rr_nxt    = 1'b1;
            beat_nxt  = '0;
          end else begin
            beat_nxt  = beat_inc;
          end
        end else begin
          // The owner dropped its request: release the lock without an ack.
          state_nxt = ST_IDLE;
          beat_nxt  = '0;
        end
      end
      ST_OWN1: begin
        if (req1) begin
          gnt1 = 1'b1;
          if ((req0 && beat_inc == CNT_MAX) || !lock1) begin
            state_nxt = ST_IDLE;
            rr_nxt    = 1'b0;
            beat_nxt  = '0;
          end else begin
            beat_nxt  = beat_inc;
          end
        end else begin
          state_nxt = ST_IDLE;
          beat_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        beat_nxt  = '0;
        if (req0 && (!req1 || !rr)) begin
          gnt0 = 1'b1;
          // With BURST_MAX of 1, a contested lock ends on its first beat.
          if (lock0 && !(req1 && BURST_MAX <= 1)) begin
            state_nxt = ST_OWN0;
            beat_nxt  = CNT_ONE;
          end else begin
            rr_nxt    = 1'b1;
          end
        end else if (req1) begin
          gnt1 = 1'b1;
          if (lock1 && !(req0 && BURST_MAX <= 1)) begin
            state_nxt = ST_OWN1;
            beat_nxt  = CNT_ONE;
          end else begin
            rr_nxt    = 1'b0;
          end
        end
      end
    endcase
    // Nothing is accepted while reset is held.
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign ack0  = gnt0;
  assign ack1  = gnt1;
  assign owner = state;

  // Register the arbiter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rr       <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr       <= rr_nxt;
      beat_cnt <= beat_nxt;
    end
  end

  // A granted write commits at the ack edge. At most one port is granted.
  always_ff @(posedge clk) begin
    if (gnt0 && we0) begin
      mem[addr0] <= wdata0;
    end else if (gnt1 && we1) begin
      mem[addr1] <= wdata1;
    end
  end

  // Port 0 read return: capture the data at the ack edge, and raise rvalid
  // for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rdata0  <= '0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      if (gnt0 && !we0) rdata0 <= mem[addr0];
    end
  end

  // Port 1 read return.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid1 <= 1'b0;
      rdata1  <= '0;
    end else begin
      rvalid1 <= gnt1 && !we1;
      if (gnt1 && !we1) rdata1 <= mem[addr1];
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: table-driven cycle vectors with expected acks and owner,
// plus a read-data scoreboard fed from a bench-side memory model.
module tb_data_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [1:0]    owner;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
    .owner(owner)
  );

  typedef struct {
    logic          rst;
    logic          req0, we0, lock0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1, we1, lock1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          e_ack0, e_ack1;
    logic [1:0]    e_owner;
  } vec_t;

  vec_t          tv[$];
  logic [DW-1:0] model [64];
  logic [DW-1:0] exp_q0[$], exp_q1[$];
  logic          pend0 = 1'b0, pend1 = 1'b0;
  int            n_chk = 0, n_pass = 0;

  function automatic vec_t mk(input int rst, input int r0, input int w0, input int l0,
                              input int a0, input logic [31:0] d0,
                              input int r1, input int w1, input int l1,
                              input int a1, input logic [31:0] d1,
                              input int e0, input int e1, input int eo);
    vec_t v;
    v.rst = rst[0];
    v.req0 = r0[0]; v.we0 = w0[0]; v.lock0 = l0[0]; v.addr0 = AW'(a0); v.wdata0 = d0;
    v.req1 = r1[0]; v.we1 = w1[0]; v.lock1 = l1[0]; v.addr1 = AW'(a1); v.wdata1 = d1;
    v.e_ack0 = e0[0]; v.e_ack1 = e1[0]; v.e_owner = eo[1:0];
    return v;
  endfunction

  function automatic vec_t idle(input int eo);
    return mk(0, 0,0,0,0,0, 0,0,0,0,0, 0,0,eo);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive one cycle, check it at the falling edge, then update the model.
  task automatic step(input vec_t v, input string tag);
    logic [DW-1:0] e;
    reset = v.rst;
    req0 = v.req0; we0 = v.we0; lock0 = v.lock0; addr0 = v.addr0; wdata0 = v.wdata0;
    req1 = v.req1; we1 = v.we1; lock1 = v.lock1; addr1 = v.addr1; wdata1 = v.wdata1;
    @(negedge clk);
    chk({tag, " ack0"},    32'(ack0),    32'(v.e_ack0));
    chk({tag, " ack1"},    32'(ack1),    32'(v.e_ack1));
    chk({tag, " owner"},   32'(owner),   32'(v.e_owner));
    chk({tag, " rvalid0"}, 32'(rvalid0), 32'(pend0));
    chk({tag, " rvalid1"}, 32'(rvalid1), 32'(pend1));
    if (pend0) begin
      e = exp_q0.pop_front();
      chk({tag, " rdata0"}, rdata0, e);
    end
    if (pend1) begin
      e = exp_q1.pop_front();
      chk({tag, " rdata1"}, rdata1, e);
    end
    pend0 = 1'b0;
    pend1 = 1'b0;
    if (!v.rst) begin
      if (v.e_ack0) begin
        if (v.we0) model[v.addr0] = v.wdata0;
        else begin exp_q0.push_back(model[v.addr0]); pend0 = 1'b1; end
      end
      if (v.e_ack1) begin
        if (v.we1) model[v.addr1] = v.wdata1;
        else begin exp_q1.push_back(model[v.addr1]); pend1 = 1'b1; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) model[i] = '0;
    reset = 1'b1;
    req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;

    // Write then read on port 0; reset gates a request.
    tv.push_back(mk(1, 1,1,0,5,32'hDEADBEEF, 0,0,0,0,0, 0,0,0));
    tv.push_back(mk(0, 1,1,0,5,32'hDEADBEEF, 0,0,0,0,0, 1,0,0));
    tv.push_back(mk(0, 1,0,0,5,0,            0,0,0,0,0, 1,0,0));
    tv.push_back(idle(0));
    tv.push_back(mk(1, 0,0,0,0,0, 0,0,0,0,0, 0,0,0));
    // Both ports requesting with no lock: grants alternate.
    tv.push_back(mk(0, 1,0,0,5,0, 1,1,0,9,32'h11111111,  1,0,0));
    tv.push_back(mk(0, 1,0,0,9,0, 1,1,0,9,32'h11111111,  0,1,0));
    tv.push_back(mk(0, 1,0,0,9,0, 1,1,0,10,32'h22222222, 1,0,0));
    tv.push_back(mk(0, 1,0,0,5,0, 1,1,0,10,32'h22222222, 0,1,0));
    tv.push_back(mk(0, 1,0,0,5,0, 0,0,0,0,0,             1,0,0));
    // Port 1 locked burst; port 0 contends from the 2nd beat and is forced in.
    tv.push_back(mk(0, 0,0,0,0,0, 1,1,1,0,32'h100, 0,1,0));
    tv.push_back(mk(0, 1,0,0,9,0, 1,1,1,1,32'h101, 0,1,2));
    tv.push_back(mk(0, 1,0,0,9,0, 1,1,1,2,32'h102, 0,1,2));
    tv.push_back(mk(0, 1,0,0,9,0, 1,1,1,3,32'h103, 0,1,2));
    tv.push_back(mk(0, 1,0,0,9,0, 1,1,1,4,32'h104, 1,0,0));
    tv.push_back(mk(0, 0,0,0,0,0, 1,1,1,4,32'h104, 0,1,0));
    tv.push_back(mk(0, 0,0,0,0,0, 1,1,1,5,32'h105, 0,1,2));
    tv.push_back(mk(0, 0,0,0,0,0, 1,1,1,6,32'h106, 0,1,2));
    tv.push_back(mk(0, 0,0,0,0,0, 1,1,0,7,32'h107, 0,1,2));
    tv.push_back(idle(0));
    // Lone locked requester: 8 beats with no forced release.
    for (int i = 0; i < 8; i++)
      tv.push_back(mk(0, 0,0,0,0,0, 1,1,1,16+i,32'h200+i, 0,1,(i == 0) ? 0 : 2));
    tv.push_back(mk(0, 0,0,0,0,0, 1,1,0,24,32'h218, 0,1,2));
    tv.push_back(idle(0));
    tv.push_back(mk(0, 0,0,0,0,0, 1,0,0,20,0, 0,1,0));
    tv.push_back(idle(0));
    // Locked owner drops its request; the waiting port gets in afterwards.
    tv.push_back(mk(0, 1,0,1,0,0, 1,1,0,30,32'h300, 1,0,0));
    tv.push_back(mk(0, 0,0,1,0,0, 1,1,0,30,32'h300, 0,0,1));
    tv.push_back(mk(0, 0,0,0,0,0, 1,1,0,30,32'h300, 0,1,0));
    tv.push_back(idle(0));
    // Reset right after a read ack; memory survives.
    tv.push_back(mk(0, 1,1,0,3,32'h12345678, 0,0,0,0,0, 1,0,0));
    tv.push_back(mk(0, 1,0,0,3,0,            0,0,0,0,0, 1,0,0));
    tv.push_back(mk(1, 0,0,0,0,0,            0,0,0,0,0, 0,0,0));
    tv.push_back(idle(0));
    tv.push_back(mk(0, 1,0,0,3,0,            0,0,0,0,0, 1,0,0));
    tv.push_back(idle(0));
    // Reset mid-burst: state and rr pointer return to their reset values.
    tv.push_back(mk(0, 0,0,0,0,0,             1,1,1,40,32'hA5A5A5A5, 0,1,0));
    tv.push_back(mk(1, 0,0,0,0,0,             1,1,1,41,32'h0B0B0B0B, 0,0,2));
    tv.push_back(mk(0, 1,1,0,42,32'hC0C0C0C0, 1,1,1,41,32'h0B0B0B0B, 1,0,0));
    tv.push_back(mk(0, 0,0,0,0,0,             1,1,1,41,32'h0B0B0B0B, 0,1,0));
    tv.push_back(mk(0, 0,0,0,0,0,             1,1,0,43,32'h0D0D0D0D, 0,1,2));
    tv.push_back(idle(0));
    tv.push_back(mk(0, 1,0,0,40,0,            0,0,0,0,0,             1,0,0));
    tv.push_back(idle(0));

    foreach (tv[i]) step(tv[i], $sformatf("v%0d", i));

    // The count stops at BURST_MAX while port 1 is alone; when port 0 arrives,
    // the next port 1 beat is its last.
    step(mk(0, 0,0,0,0,0, 1,1,1,50,32'h500, 0,1,0), "h0");
    for (int i = 1; i <= 5; i++)
      step(mk(0, 0,0,0,0,0, 1,1,1,50+i,32'h500+i, 0,1,2), $sformatf("h%0d", i));
    step(mk(0, 1,0,0,50,0, 1,1,1,56,32'h506, 0,1,2), "h6");
    step(mk(0, 1,0,0,50,0, 1,1,1,57,32'h507, 1,0,0), "h7");
    step(mk(0, 0,0,0,0,0,  1,1,0,57,32'h507, 0,1,0), "h8");
    step(idle(0), "h9");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
